// File: rtl/buf_stage_pkg.sv
// Shared router constants and helpers used by the buffering stages.
package buf_stage_pkg;

  localparam int BUF_WIDTH = 11;
  localparam int BUF_DEPTH = 4;

  // Occupancy states of a buffer stage.
  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_e;

  function automatic occ_e occ_of(input int count, input int depth);
    if (count == 0) begin
      return OCC_EMPTY;
    end
    if (count >= depth) begin
      return OCC_FULL;
    end
    return OCC_PARTIAL;
  endfunction

endpackage

// File: rtl/buf_stage.sv
// Valid/ready FIFO stage: register array with read/write pointers and an
// occupancy counter; one cycle of latency and no in->out combinational path.
module buf_stage
  import buf_stage_pkg::*;
#(
  parameter int WIDTH = BUF_WIDTH,
  parameter int DEPTH = BUF_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic          push;
  logic          pop;

  // Flags depend only on registered count, so in_ready never sees out_ready.
  assign in_ready  = (count_reg < FULL_COUNT);
  assign out_valid = (count_reg != '0);
  assign out_data  = mem[rd_ptr_reg];

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (push) begin
      wr_ptr_next = wr_ptr_reg + PW'(1);
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Storage is never reset; the write is gated so a reset edge stores nothing.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr_reg] <= in_data;
    end
  end

endmodule

// File: tb/tb_buf_stage.sv
// Directed scoreboard bench for buf_stage: driver pushes expected words,
// a monitor pops and compares on every output transfer.
module tb_buf_stage;

  localparam int W = 11;

  logic         clk;
  logic         rst;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;

  int checks;
  int passes;
  logic [W-1:0] sb[$];

  buf_stage dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) begin
      passes++;
      $display("check %s actual=0x%0h expected=0x%0h ok", name, act, exp);
    end else begin
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: an output transfer happens at the next rising edge when these
  // are high at the falling edge (inputs only change just after rising edges).
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 32'(out_data), 32'h7FFF_FFFF);
        end else begin
          check("out_word", 32'(out_data), 32'(sb.pop_front()));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d, input int budget, output bit ok);
    ok       = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(d);
        ok = 1'b1;
      end
      tick();
      if (ok) break;
    end
    in_valid = 1'b0;
    in_data  = 11'h7FF;  // garbage while idle must be ignored
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((sb.size() != 0 || out_valid) && n < 50) begin
      tick();
      n++;
    end
    check({name, "_drained"}, 32'(sb.size()), 32'd0);
    check({name, "_empty_valid"}, 32'(out_valid), 32'd0);
  endtask

  logic [W-1:0] seq_words [4] = '{11'h2A5, 11'h0CE, 11'h7CD, 11'h788};
  logic [W-1:0] fill_words[5] = '{11'h111, 11'h222, 11'h333, 11'h444, 11'h555};

  initial begin
    bit ok;
    int acc;
    checks    = 0;
    passes    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);

    // Single word with one-cycle latency.
    out_ready = 1'b1;
    send(11'h2A5, 5, ok);
    check("single_accepted", 32'(ok), 32'd1);
    check("single_valid_after_edge", 32'(out_valid), 32'd1);
    check("single_data", 32'(out_data), 32'h2A5);
    tick();
    check("single_then_empty", 32'(out_valid), 32'd0);

    // Sequence with 10-cycle gaps.
    foreach (seq_words[i]) begin
      send(seq_words[i], 5, ok);
      check("seq_accepted", 32'(ok), 32'd1);
      repeat (10) tick();
    end
    drain("seq");

    // Fill: only DEPTH words accepted while out_ready is low.
    out_ready = 1'b0;
    acc = 0;
    foreach (fill_words[i]) begin
      send(fill_words[i], 3, ok);
      if (ok) acc++;
    end
    check("fill_accepted", 32'(acc), 32'd4);
    check("fill_in_ready", 32'(in_ready), 32'd0);
    check("fill_out_valid", 32'(out_valid), 32'd1);
    drain("fill");

    // Backpressure holds head stable.
    out_ready = 1'b0;
    send(11'h6B3, 5, ok);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_data", 32'(out_data), 32'h6B3);
    end
    drain("bp");

    // Concurrent push/pop at count=2 across pointer wrap.
    out_ready = 1'b0;
    send(11'h0A1, 5, ok);
    send(11'h0A2, 5, ok);
    check("conc_count_start", 32'(dut.count_reg), 32'd2);
    for (int i = 0; i < 8; i++) begin
      in_valid  = 1'b1;
      in_data   = 11'(11'h100 + i);
      out_ready = 1'b1;
      @(negedge clk);
      if (in_ready) sb.push_back(in_data);
      check("conc_in_ready", 32'(in_ready), 32'd1);
      tick();
      check("conc_count", 32'(dut.count_reg), 32'd2);
    end
    in_valid = 1'b0;
    drain("conc");

    // Reset with three words stored discards them.
    out_ready = 1'b0;
    send(11'h301, 5, ok);
    send(11'h302, 5, ok);
    send(11'h303, 5, ok);
    check("rst_pre_count", 32'(dut.count_reg), 32'd3);
    rst = 1'b1;
    #1;
    check("rst_async_out_valid", 32'(out_valid), 32'd0);
    check("rst_async_in_ready", 32'(in_ready), 32'd1);
    sb.delete();
    tick();
    rst       = 1'b0;
    out_ready = 1'b1;
    repeat (5) tick();
    check("rst_no_emit", 32'(out_valid), 32'd0);

    check("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
